// File: rtl/div8by4_seq.sv
// Radix-2 restoring divider, one quotient bit per clock.
// Valid/ready handshakes on operand input and result output.
module div8by4_seq #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  localparam int C_W = $clog2(N_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0] dvd_q, dvd_d;
  logic [D_W-1:0] dvs_q, dvs_d;
  logic [D_W:0]   prem_q, prem_d;
  logic [N_W-1:0] quot_q, quot_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [D_W:0]   trial;
  logic           ge;
  logic [D_W:0]   step_rem;
  logic [N_W-1:0] step_dvd;

  // dvd_q shifts out dividend bits at the top and collects quotient bits
  // at the bottom, so it holds the quotient after the last step.
  always_comb begin
    trial    = {prem_q[D_W-1:0], dvd_q[N_W-1]};
    ge       = (trial >= {1'b0, dvs_q});
    step_rem = ge ? (trial - {1'b0, dvs_q}) : trial;
    step_dvd = {dvd_q[N_W-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          cnt_d  = C_W'(N_W);
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend[D_W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prem_d = step_rem;
        dvd_d  = step_dvd;
        cnt_d  = cnt_q - C_W'(1);
        if (cnt_q == C_W'(1)) begin
          quot_d  = step_dvd;
          rem_d   = step_rem[D_W-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8by4_seq.sv
// Directed plus random checks of div8by4_seq against plain
// integer division.
module tb_div8by4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div8by4_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: plain integer division; divide by zero gives all ones and
  // the low divisor-width bits of the dividend.
  task automatic run_op(input logic [7:0] dd, input logic [3:0] ds,
                        input int hold);
    int eq, er, ez, elat, lat;
    if (ds == 0) begin
      eq = 255; er = dd % 16; ez = 1; elat = 0;
    end else begin
      eq = dd / ds; er = dd % ds; ez = 0; elat = 8;
    end
    chk("ready_before", int'(in_ready), 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    dividend  = dd;
    divisor   = ds;
    tick();
    in_valid = 1'b0;
    dividend = $urandom_range(0, 255);
    divisor  = $urandom_range(0, 15);
    chk("ready_after_acc", int'(in_ready), 0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      in_valid = 1'b1;
      tick();
      lat++;
      if (out_valid !== 1'b1) chk("ready_busy", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    chk("latency", lat, elat);
    chk("quotient", int'(quotient), eq);
    chk("remainder", int'(remainder), er);
    chk("dbz", int'(div_by_zero), ez);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
      chk("hold_quot", int'(quotient), eq);
      chk("hold_rem", int'(remainder), er);
    end
    out_ready = 1'b1;
    tick();
    chk("valid_drop", int'(out_valid), 0);
    chk("ready_back", int'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quot", int'(quotient), 0);
    chk("rst_rem", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    tick();

    run_op(8'd6, 4'd2, 0);
    run_op(8'd28, 4'd4, 0);
    run_op(8'd27, 4'd3, 0);
    run_op(8'd225, 4'd15, 0);
    run_op(8'd48, 4'd8, 0);
    run_op(8'd200, 4'd7, 0);
    run_op(8'd255, 4'd1, 0);
    run_op(8'd5, 4'd15, 0);
    run_op(8'hA7, 4'd0, 0);
    run_op(8'd100, 4'd9, 5);

    // Reset during the 4th iteration discards the operation.
    in_valid = 1'b1;
    dividend = 8'd225;
    divisor  = 4'd15;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_quot", int'(quotient), 0);
    chk("mid_rst_rem", int'(remainder), 0);
    chk("mid_rst_dbz", int'(div_by_zero), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_rst_no_out", int'(out_valid), 0);
    end
    run_op(8'd6, 4'd2, 0);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] rd;
      logic [3:0] rs;
      rd = 8'($urandom_range(0, 255));
      rs = (i % 7 == 3) ? 4'd0 : 4'($urandom_range(0, 15));
      run_op(rd, rs, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
